multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3, giving the ALUControl width; legal values are 3 or more, and bits above [2] SHALL be driven 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Cond, input, 4 bits: instruction condition field.
REQ-005 SHALL have port Op, input, 2 bits: instruction class (00 DP, 01 memory, 10 branch).
REQ-006 SHALL have port Funct, input, 6 bits: I bit [5], cmd [4:1], S/L bit [0].
REQ-007 SHALL have port Rd, input, 4 bits: destination register.
REQ-008 SHALL have port ALUFlags, input, 4 bits: NZCV from the ALU, used in the current cycle.
REQ-009 SHALL have outputs PCWrite, MemW, RegW, IRWrite, AdrSrc and ALUSrcA, 1 bit each: datapath strobes and selects.
REQ-010 SHALL have outputs ResultSrc, ALUSrcB, ImmSrc and RegSrc, 2 bits each: datapath selects.
REQ-011 SHALL have output ALUControl, ALUCTRL_W bits: ALU operation.

Function
REQ-012 SHALL implement FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB and BRANCH.
REQ-013 SHALL sequence FETCH->DECODE, then DECODE->MEMADR (Op=01), EXECR (Op=00, I=0), EXECI (Op=00, I=1) or BRANCH (Op=10); Op=11 SHALL return to FETCH.
REQ-014 SHALL sequence MEMADR->MEMRD (L=1) or MEMWR (L=0); MEMRD->MEMWB; EXECR and EXECI->ALUWB; MEMWB, MEMWR, ALUWB and BRANCH SHALL go to FETCH.
REQ-015 SHALL take the following cycle counts per instruction: LDR 5, STR 4, DP 4, B 3, undefined 2.
REQ-016 SHALL assert, in FETCH, IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD and ResultSrc=10.
REQ-017 SHALL drive, in DECODE, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD and ResultSrc=10.
REQ-018 SHALL assert AdrSrc=1 in MEMRD and MEMWR, and ResultSrc=01 with RegW in MEMWB.
REQ-019 SHALL assert RegW in ALUWB with ResultSrc=00, and SHALL also assert PCWrite there when Rd=15.
REQ-020 SHALL use ALU encodings ADD 000, SUB 001, AND 010, ORR 011 and EOR 100, decoded from cmd 0100, 0010, 0000, 1100 and 0001 respectively; any other cmd SHALL select ADD with all writes suppressed.
REQ-021 SHALL drive ImmSrc as 00 for DP, 01 for memory and 10 for branch, and RegSrc as bit0=1 for branch and bit1=1 for STR.
REQ-022 SHALL hold a 4-bit NZCV Flags register, reset to 0.
REQ-023 SHALL compute CondEx from Cond and Flags using all 15 ARM conditions; Cond=1111 SHALL give CondEx=0.
REQ-024 SHALL gate RegW, MemW, the ALUWB/BRANCH PCWrite and the flag update with CondEx; FETCH PCWrite and IRWrite SHALL be ungated.
REQ-025 SHALL, in EXECR/EXECI with S=1 and CondEx=1, load NZ always and load CV only for ADD/SUB, on the next edge.
REQ-026 SHALL evaluate CondEx against the Flags value before any update made in the same cycle.
REQ-027 SHALL make all outputs a combinational function of state, inputs and Flags, with no output registers.

Reset
REQ-028 SHALL, on reset assertion, immediately force the state to FETCH and Flags to 0000, regardless of the current state.
REQ-029 SHALL hold all strobes at the FETCH values while reset is high, and SHALL suppress MemW and RegW during reset.
REQ-030 SHALL start FETCH on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL, with CMP_TST_EN defined, decode cmd 1010 as CMP (SUB) and cmd 1000 as TST (AND), updating flags only and suppressing RegW in ALUWB.
REQ-032 SHALL, without CMP_TST_EN, treat cmd 1010 and 1000 as undefined per REQ-020.

Verification
REQ-033 Bench SHALL cover: reset asserted mid-MEMRD -> state is FETCH before the next edge, MemW=0, RegW=0, Flags=0000.
REQ-034 Bench SHALL cover: ADDS with ALUFlags=0110 -> Flags=0110 after EXECR; a following BEQ (Cond=0000) takes 3 cycles with PCWrite=1 in BRANCH.
REQ-035 Bench SHALL cover: LDR with Rd=15 -> 5 cycles and RegW=1 only in MEMWB; STR -> MemW=1 only in MEMWR.
REQ-036 Bench SHALL cover: ANDS with Cond=0001 and Flags.Z=1 -> RegW=0, Flags unchanged, back to FETCH after 4 cycles.
REQ-037 Bench SHALL cover: CMP with operands equal -> with CMP_TST_EN, Z=1 and RegW=0; without CMP_TST_EN, no flag or register write.
REQ-038 Bench SHALL cover: ALUCTRL_W=5 with EOR -> ALUControl=00100.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: instruction sequencing FSM, ALU decode,
// NZCV flag register and condition evaluation. All outputs are combinational
// from state, instruction fields and the flags.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   Cond, Op, Funct, Rd     instruction fields (held by the IR for the whole
//                           instruction)
//   ALUFlags                NZCV from the ALU in the current cycle
//   PCWrite, MemW, RegW,
//   IRWrite, AdrSrc,
//   ALUSrcA                 datapath strobes / 1-bit selects
//   ResultSrc, ALUSrcB,
//   ImmSrc, RegSrc          datapath 2-bit selects
//   ALUControl              ALU operation, zero-extended to ALUCTRL_W
//
// Build option
//   CMP_TST_EN              when defined, cmd 1010 decodes as CMP and
//                           cmd 1000 as TST (flags only, no register write)
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4
// DECODE | read registers, compute PC+8
// MEMADR | compute memory address
// MEMRD  | read data memory
// MEMWB  | write loaded word to register file
// MEMWR  | write data memory
// EXECR  | data-processing, register operand
// EXECI  | data-processing, immediate operand
// ALUWB  | write ALU result to register file (and PC when Rd=15)
// BRANCH | write branch target to PC

module multicycle_controller #(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 MemW,
  output logic                 RegW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

`ifdef CMP_TST_EN
  localparam bit CmpTstEn = 1'b1;
`else
  localparam bit CmpTstEn = 1'b0;
`endif

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] st;
  logic       cond_ex;
  logic [2:0] alu_op, alu3;
  logic       cmd_valid, cmd_wr_reg, cmd_cv;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // cmd_valid gates flag updates; cmd_wr_reg gates the ALUWB register/PC write.
  always_comb begin
    alu_op     = ALU_ADD;
    cmd_valid  = 1'b1;
    cmd_wr_reg = 1'b1;
    cmd_cv     = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_op = ALU_ADD; cmd_cv = 1'b1; end
      4'b0010: begin alu_op = ALU_SUB; cmd_cv = 1'b1; end
      4'b0000: alu_op = ALU_AND;
      4'b1100: alu_op = ALU_ORR;
      4'b0001: alu_op = ALU_EOR;
      4'b1010: begin
        if (CmpTstEn) begin
          alu_op     = ALU_SUB;
          cmd_cv     = 1'b1;
          cmd_wr_reg = 1'b0;
        end else begin
          cmd_valid  = 1'b0;
          cmd_wr_reg = 1'b0;
        end
      end
      4'b1000: begin
        if (CmpTstEn) begin
          alu_op     = ALU_AND;
          cmd_wr_reg = 1'b0;
        end else begin
          cmd_valid  = 1'b0;
          cmd_wr_reg = 1'b0;
        end
      end
      default: begin
        cmd_valid  = 1'b0;
        cmd_wr_reg = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // Flags load on the edge closing the execute cycle; CV only for add/subtract.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == EXECR || state_q == EXECI) && Funct[0] && cond_ex && cmd_valid) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (cmd_cv) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Outputs follow FETCH for as long as reset is held.
  assign st = reset ? FETCH : state_q;

  always_comb begin
    PCWrite   = 1'b0;
    MemW      = 1'b0;
    RegW      = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcB   = 2'b00;
    alu3      = ALU_ADD;
    case (st)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = cond_ex;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = cond_ex;
      end
      EXECR: alu3 = alu_op;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu3    = alu_op;
      end
      ALUWB: begin
        RegW    = cond_ex & cmd_wr_reg;
        PCWrite = cond_ex & cmd_wr_reg & (Rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    if (Op == 2'b01) ImmSrc = 2'b01;
    else if (Op == 2'b10) ImmSrc = 2'b10;
  end

  assign RegSrc     = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
  assign ALUControl = ALUCTRL_W'(alu3);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;

  logic       PCWrite, MemW, RegW, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;

  logic       PCWrite5, MemW5, RegW5, IRWrite5, AdrSrc5, ALUSrcA5;
  logic [1:0] ResultSrc5, ALUSrcB5, ImmSrc5, RegSrc5;
  logic [4:0] ALUControl5;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemW(MemW), .RegW(RegW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  multicycle_controller #(.ALUCTRL_W(5)) dut5 (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite5), .MemW(MemW5), .RegW(RegW5),
    .IRWrite(IRWrite5), .AdrSrc(AdrSrc5), .ALUSrcA(ALUSrcA5), .ResultSrc(ResultSrc5),
    .ALUSrcB(ALUSrcB5), .ImmSrc(ImmSrc5), .RegSrc(RegSrc5), .ALUControl(ALUControl5)
  );

  logic [16:0] act;
  logic [18:0] act5;
  assign act  = {PCWrite, MemW, RegW, IRWrite, AdrSrc, ALUSrcA, ResultSrc, ALUSrcB,
                 ImmSrc, RegSrc, ALUControl};
  assign act5 = {PCWrite5, MemW5, RegW5, IRWrite5, AdrSrc5, ALUSrcA5, ResultSrc5, ALUSrcB5,
                 ImmSrc5, RegSrc5, ALUControl5};

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cond;
    logic [3:0]  rd;
    logic [3:0]  af;
    logic [16:0] exp;
    logic [3:0]  ef;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];
  logic [3:0]  expf_q[$];
  int          checks = 0;
  int          failures = 0;

`ifdef CMP_TST_EN
  localparam logic [3:0] FL_CMP  = 4'b0110;
  localparam logic [2:0] ALU_CMP = 3'b001;
`else
  localparam logic [3:0] FL_CMP  = 4'b1010;
  localparam logic [2:0] ALU_CMP = 3'b000;
`endif

  function automatic logic [16:0] o(input logic pcw, memw, regw, irw, adr, asa,
                                    input logic [1:0] rs, asb, imm, rsrc,
                                    input logic [2:0] alu);
    return {pcw, memw, regw, irw, adr, asa, rs, asb, imm, rsrc, alu};
  endfunction

  function automatic logic [16:0] fe(input logic [1:0] imm, rsrc);
    return o(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, imm, rsrc, 3'b000);
  endfunction

  function automatic logic [16:0] de(input logic [1:0] imm, rsrc);
    return o(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, imm, rsrc, 3'b000);
  endfunction

  task automatic add(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] cond,
                     input logic [3:0] rd, input logic [3:0] af, input logic [16:0] exp,
                     input logic [3:0] ef);
    vec_t v;
    v.op = op; v.funct = funct; v.cond = cond; v.rd = rd; v.af = af; v.exp = exp; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] cond,
                       input logic [3:0] rd, input logic [3:0] af);
    Op = op; Funct = funct; Cond = cond; Rd = rd; ALUFlags = af;
  endtask

  localparam logic [16:0] EXR  = 17'b0;
  localparam logic [16:0] WB0  = 17'b0;

  initial begin
    logic [16:0] e;
    logic [3:0]  ef;

    reset = 1'b1;
    drive(2'b00, 6'b0, 4'b1110, 4'd0, 4'b0);

    // ADDS R1 (AL), ALU reports Z and C
    add(2'b00, 6'b001001, 4'b1110, 4'd1, 4'b0110, fe(2'b00, 2'b00), 4'b0000);
    add(2'b00, 6'b001001, 4'b1110, 4'd1, 4'b0110, de(2'b00, 2'b00), 4'b0000);
    add(2'b00, 6'b001001, 4'b1110, 4'd1, 4'b0110, EXR, 4'b0000);
    add(2'b00, 6'b001001, 4'b1110, 4'd1, 4'b0110, o(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), 4'b0110);
    // BEQ taken: 3 cycles
    add(2'b10, 6'b000000, 4'b0000, 4'd0, 4'b0000, fe(2'b10, 2'b01), 4'b0110);
    add(2'b10, 6'b000000, 4'b0000, 4'd0, 4'b0000, de(2'b10, 2'b01), 4'b0110);
    add(2'b10, 6'b000000, 4'b0000, 4'd0, 4'b0000, o(1,0,0,0,0,0,2'b10,2'b01,2'b10,2'b01,3'b000), 4'b0110);
    // LDR Rd=15: 5 cycles, RegW only in MEMWB
    add(2'b01, 6'b011001, 4'b1110, 4'd15, 4'b0000, fe(2'b01, 2'b00), 4'b0110);
    add(2'b01, 6'b011001, 4'b1110, 4'd15, 4'b0000, de(2'b01, 2'b00), 4'b0110);
    add(2'b01, 6'b011001, 4'b1110, 4'd15, 4'b0000, o(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), 4'b0110);
    add(2'b01, 6'b011001, 4'b1110, 4'd15, 4'b0000, o(0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b00,3'b000), 4'b0110);
    add(2'b01, 6'b011001, 4'b1110, 4'd15, 4'b0000, o(0,0,1,0,0,0,2'b01,2'b00,2'b01,2'b00,3'b000), 4'b0110);
    // STR: 4 cycles, MemW only in MEMWR
    add(2'b01, 6'b011000, 4'b1110, 4'd2, 4'b0000, fe(2'b01, 2'b10), 4'b0110);
    add(2'b01, 6'b011000, 4'b1110, 4'd2, 4'b0000, de(2'b01, 2'b10), 4'b0110);
    add(2'b01, 6'b011000, 4'b1110, 4'd2, 4'b0000, o(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000), 4'b0110);
    add(2'b01, 6'b011000, 4'b1110, 4'd2, 4'b0000, o(0,1,0,0,1,0,2'b00,2'b00,2'b01,2'b10,3'b000), 4'b0110);
    // ANDSNE with Z=1: not executed
    add(2'b00, 6'b000001, 4'b0001, 4'd3, 4'b1000, fe(2'b00, 2'b00), 4'b0110);
    add(2'b00, 6'b000001, 4'b0001, 4'd3, 4'b1000, de(2'b00, 2'b00), 4'b0110);
    add(2'b00, 6'b000001, 4'b0001, 4'd3, 4'b1000, o(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b010), 4'b0110);
    add(2'b00, 6'b000001, 4'b0001, 4'd3, 4'b1000, WB0, 4'b0110);
    // EORS immediate: NZ loaded, CV kept
    add(2'b00, 6'b100011, 4'b1110, 4'd4, 4'b1011, fe(2'b00, 2'b00), 4'b0110);
    add(2'b00, 6'b100011, 4'b1110, 4'd4, 4'b1011, de(2'b00, 2'b00), 4'b0110);
    add(2'b00, 6'b100011, 4'b1110, 4'd4, 4'b1011, o(0,0,0,0,0,0,2'b00,2'b01,2'b00,2'b00,3'b100), 4'b0110);
    add(2'b00, 6'b100011, 4'b1110, 4'd4, 4'b1011, o(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), 4'b1010);
    // SUB to R15: PCWrite in ALUWB, no flag change
    add(2'b00, 6'b000100, 4'b1110, 4'd15, 4'b0101, fe(2'b00, 2'b00), 4'b1010);
    add(2'b00, 6'b000100, 4'b1110, 4'd15, 4'b0101, de(2'b00, 2'b00), 4'b1010);
    add(2'b00, 6'b000100, 4'b1110, 4'd15, 4'b0101, o(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b001), 4'b1010);
    add(2'b00, 6'b000100, 4'b1110, 4'd15, 4'b0101, o(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), 4'b1010);
    // Op=11: 2 cycles
    add(2'b11, 6'b000000, 4'b1110, 4'd0, 4'b0000, fe(2'b00, 2'b00), 4'b1010);
    add(2'b11, 6'b000000, 4'b1110, 4'd0, 4'b0000, de(2'b00, 2'b00), 4'b1010);
    // CMP with equal operands
    add(2'b00, 6'b010101, 4'b1110, 4'd0, 4'b0110, fe(2'b00, 2'b00), 4'b1010);
    add(2'b00, 6'b010101, 4'b1110, 4'd0, 4'b0110, de(2'b00, 2'b00), 4'b1010);
    add(2'b00, 6'b010101, 4'b1110, 4'd0, 4'b0110, o(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,ALU_CMP), 4'b1010);
    add(2'b00, 6'b010101, 4'b1110, 4'd0, 4'b0110, WB0, FL_CMP);
    // ORRS with Cond=1111 (never)
    add(2'b00, 6'b011001, 4'b1111, 4'd5, 4'b0100, fe(2'b00, 2'b00), FL_CMP);
    add(2'b00, 6'b011001, 4'b1111, 4'd5, 4'b0100, de(2'b00, 2'b00), FL_CMP);
    add(2'b00, 6'b011001, 4'b1111, 4'd5, 4'b0100, o(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b011), FL_CMP);
    add(2'b00, 6'b011001, 4'b1111, 4'd5, 4'b0100, WB0, FL_CMP);
    // undefined cmd 0111 with S: ADD, nothing written
    add(2'b00, 6'b001111, 4'b1110, 4'd6, 4'b1111, fe(2'b00, 2'b00), FL_CMP);
    add(2'b00, 6'b001111, 4'b1110, 4'd6, 4'b1111, de(2'b00, 2'b00), FL_CMP);
    add(2'b00, 6'b001111, 4'b1110, 4'd6, 4'b1111, EXR, FL_CMP);
    add(2'b00, 6'b001111, 4'b1110, 4'd6, 4'b1111, WB0, FL_CMP);
    // plain ADD R7
    add(2'b00, 6'b001000, 4'b1110, 4'd7, 4'b1111, fe(2'b00, 2'b00), FL_CMP);
    add(2'b00, 6'b001000, 4'b1110, 4'd7, 4'b1111, de(2'b00, 2'b00), FL_CMP);
    add(2'b00, 6'b001000, 4'b1110, 4'd7, 4'b1111, EXR, FL_CMP);
    add(2'b00, 6'b001000, 4'b1110, 4'd7, 4'b1111, o(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), FL_CMP);

    @(negedge clk);
    #1;
    chk("reset_outs", 32'(act), 32'(fe(2'b00, 2'b00)));
    chk("reset_flags", 32'(dut.flags_q), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b0;
      drive(vecs[i].op, vecs[i].funct, vecs[i].cond, vecs[i].rd, vecs[i].af);
      exp_q.push_back(vecs[i].exp);
      expf_q.push_back(vecs[i].ef);
      #2;
      e  = exp_q.pop_front();
      ef = expf_q.pop_front();
      chk($sformatf("vec%0d_outs", i), 32'(act), 32'(e));
      chk($sformatf("vec%0d_flags", i), 32'(dut.flags_q), 32'(ef));
      chk($sformatf("vec%0d_w5", i), 32'(act5), 32'({e[16:3], 2'b00, e[2:0]}));
    end

    // reset asserted in the middle of MEMRD
    drive(2'b01, 6'b011001, 4'b1110, 4'd7, 4'b0000);
    repeat (4) @(negedge clk);
    #1;
    chk("pre_reset_memrd", 32'(act), 32'(o(0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b00,3'b000)));
    chk("pre_reset_flags", 32'(dut.flags_q), 32'(FL_CMP));
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_outs", 32'(act), 32'(fe(2'b01, 2'b00)));
    chk("mid_reset_flags", 32'(dut.flags_q), 32'h0);
    @(negedge clk);
    #1;
    chk("held_reset_outs", 32'(act), 32'(fe(2'b01, 2'b00)));
    reset = 1'b0;
    #1;
    chk("post_reset_fetch", 32'(act), 32'(fe(2'b01, 2'b00)));
    @(negedge clk);
    #1;
    chk("post_reset_decode", 32'(act), 32'(de(2'b01, 2'b00)));
    chk("post_reset_flags", 32'(dut.flags_q), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
